uart_rx_deframer: RTL and testbench

//  Receives the 8N1 serial stream produced by the board's UART transmitter (115200 baud at 50 MHz).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_deframer_if.sv | 25 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_deframer.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period
// (also used by the transmitter) and a parity helper.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Receiver FSM state encoding (3 bits, encoding 7 is never used)
    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE    = 3'd0;
    localparam rx_state_t ST_START   = 3'd1;
    localparam rx_state_t ST_DATA    = 3'd2;
    localparam rx_state_t ST_PARITY  = 3'd3;
    localparam rx_state_t ST_STOP    = 3'd4;
    localparam rx_state_t ST_BREAK   = 3'd5;
    localparam rx_state_t ST_CLEANUP = 3'd6;

    // Even-parity bit for a data byte (XOR of all bits)
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Receive-side output bundle of the UART deframer.
// master: the deframer driving the byte and strobes; slave: the consumer.
interface uart_rx_deframer_if;
    logic [7:0] O_RX_BYTE;
    logic       O_RX_DV;
    logic       O_FRAME_ERR;
    logic       O_PARITY_ERR;
    logic       O_RX_BUSY;

    modport master (
        output O_RX_BYTE,
        output O_RX_DV,
        output O_FRAME_ERR,
        output O_PARITY_ERR,
        output O_RX_BUSY
    );

    modport slave (
        input O_RX_BYTE,
        input O_RX_DV,
        input O_FRAME_ERR,
        input O_PARITY_ERR,
        input O_RX_BUSY
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line.
// Flops reset to 1 so the line reads as idle while in reset.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line in at the bottom of the chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_async};
    end

    // Synchroniser chain, reset to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8N1 by default, 8E1 when UART_RX_PARITY_EN is
// defined. Validates the start bit at mid-bit, samples each data bit at
// mid-bit, checks the stop bit and emits one-cycle DV / error strobes.
import uart_pkg::*;

module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                RX_SERIAL,
    uart_rx_deframer_if.master  rx_if
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic      rx_s;
    rx_state_t state_q,   state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       dv_q,      dv_d;
    logic       ferr_q,    ferr_d;
    logic       busy_q,    busy_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bit_q, par_bit_d;
    logic       perr_q,    perr_d;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .rx_async (RX_SERIAL),
        .rx_s     (rx_s)
    );

    // Frame FSM: bit timing, data capture, stop/parity checks, strobes
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        busy_d    = busy_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = CNT_ZERO;
                bit_idx_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = CNT_ZERO;
                    if (!rx_s) begin
                        busy_d  = 1'b1;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = CNT_ZERO;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = CNT_ZERO;
                    par_bit_d = rx_s;
                    state_d   = ST_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = CNT_ZERO;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != even_parity(shift_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            rx_byte_d = shift_q;
                            dv_d      = 1'b1;
                        end
`else
                        rx_byte_d = shift_q;
                        dv_d      = 1'b1;
`endif
                        state_d = ST_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a long low
                // level is not mistaken for a new start bit
                if (rx_s) begin
                    state_d = ST_CLEANUP;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            ST_CLEANUP: begin
                clk_cnt_d = CNT_ZERO;
                bit_idx_d = 3'd0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                clk_cnt_d = CNT_ZERO;
                bit_idx_d = 3'd0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, counters, data and registered outputs
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            rx_byte_q <= 8'h00;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_if.O_RX_BYTE   = rx_byte_q;
    assign rx_if.O_RX_DV     = dv_q;
    assign rx_if.O_FRAME_ERR = ferr_q;
    assign rx_if.O_RX_BUSY   = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.O_PARITY_ERR = perr_q;
`else
    assign rx_if.O_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at CLKS_PER_BIT=434.
// Honours UART_RX_PARITY_EN (8E1 frames) when defined.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int CPB  = 434;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int EV_DV = 0;
    localparam int EV_FE = 1;
    localparam int EV_PE = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_bad;
        int         gap;
        int         exp_kind;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rx_line = 1'b1;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    logic busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;
    ev_t  obs_q[$];
    vec_t vecs[$];

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .CLOCK     (clk),
        .RESET_N   (rst_n),
        .RX_SERIAL (rx_line),
        .rx_if     (rx_if)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs every strobe event and checks exclusivity
    always @(negedge clk) begin
        int  ns;
        ev_t e;
        ns = int'(rx_if.O_RX_DV) + int'(rx_if.O_FRAME_ERR) + int'(rx_if.O_PARITY_ERR);
        if (ns != 0) begin
            n_vec++;
            if (ns > 1) begin
                n_err++;
                $display("FAIL strobe_exclusive: %0d strobes high at cycle %0d, required 1", ns, cyc);
            end
            e.kind = rx_if.O_RX_DV ? EV_DV : (rx_if.O_FRAME_ERR ? EV_FE : EV_PE);
            e.data = rx_if.O_RX_BYTE;
            e.cyc  = cyc;
            obs_q.push_back(e);
        end
        if (rx_if.O_RX_BUSY) busy_seen = 1'b1;
    end

    // Reference: outcome of a frame from its stop bit and parity validity
    function automatic int predict(input logic stop, input logic par_bad);
        if (!stop) return EV_FE;
        if (PAR_BITS != 0 && par_bad) return EV_PE;
        return EV_DV;
    endfunction

    task automatic hold(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_bad, CPB);
`endif
        hold(stop, CPB);
    endtask

    task automatic check_frame(input string name, input int exp_kind, input logic [7:0] d);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_err++;
            $display("FAIL %s events: got %0d, required 1", name, obs_q.size());
        end else if (obs_q[0].kind != exp_kind) begin
            n_err++;
            $display("FAIL %s kind: got %0d, required %0d", name, obs_q[0].kind, exp_kind);
        end else if (exp_kind == EV_DV && obs_q[0].data !== d) begin
            n_err++;
            $display("FAIL %s byte: got %02h, required %02h", name, obs_q[0].data, d);
        end
        if (exp_kind == EV_DV) last_good = d;
        n_vec++;
        if (rx_if.O_RX_BYTE !== last_good) begin
            n_err++;
            $display("FAIL %s byte_hold: got %02h, required %02h", name, rx_if.O_RX_BYTE, last_good);
        end
        obs_q.delete();
    endtask

    task automatic check_quiet(input string name, input logic exp_busy);
        n_vec++;
        if (obs_q.size() != 0 || rx_if.O_RX_BUSY !== exp_busy) begin
            n_err++;
            $display("FAIL %s: got %0d events busy=%b, required 0 events busy=%b",
                     name, obs_q.size(), rx_if.O_RX_BUSY, exp_busy);
        end
        obs_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({rx_if.O_RX_BYTE, rx_if.O_RX_DV, rx_if.O_FRAME_ERR,
             rx_if.O_PARITY_ERR, rx_if.O_RX_BUSY} !== 12'h000) begin
            n_err++;
            $display("FAIL %s: got byte=%02h dv=%b fe=%b pe=%b busy=%b, required all 0",
                     name, rx_if.O_RX_BYTE, rx_if.O_RX_DV, rx_if.O_FRAME_ERR,
                     rx_if.O_PARITY_ERR, rx_if.O_RX_BUSY);
        end
    endtask

    initial begin
        int         t0;
        int         lat;
        int         exp_lat;
        logic [7:0] d;
        logic       stop;
        logic       pb;
        int         k;

        // Vector table: back-to-back run, boundary bytes, framing error
        vecs.push_back('{8'h4D, 1'b1, 1'b0, 0,   EV_DV});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 0,   EV_DV});
        vecs.push_back('{8'h08, 1'b1, 1'b0, CPB, EV_DV});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 0,   EV_DV});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, CPB, EV_DV});
        vecs.push_back('{8'hC3, 1'b0, 1'b0, CPB, EV_FE});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, CPB, EV_DV});
        vecs.push_back('{8'h07, 1'b1, 1'b1, CPB, EV_PE});
`endif

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        hold(1'b1, 20);
        check_quiet("idle_after_reset", 1'b0);

        // Single frame with latency check
        t0 = cyc;
        send_frame(8'h53, 1'b1, 1'b0);
        exp_lat = ((19 + 2 * PAR_BITS) * CPB) / 2 + SYNC + 2;
        lat = (obs_q.size() > 0) ? (obs_q[0].cyc - t0) : -1;
        n_vec++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            n_err++;
            $display("FAIL latency_53: got %0d cycles, required %0d +/-1", lat, exp_lat);
        end
        check_frame("frame_53", EV_DV, 8'h53);

        // Table-driven frames
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_bad);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].data);
            if (vecs[i].gap > 0) hold(1'b1, vecs[i].gap);
        end

        // Short low glitch on idle line
        busy_seen = 1'b0;
        hold(1'b0, 100);
        hold(1'b1, 2 * CPB);
        n_vec++;
        if (busy_seen !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy: got busy_seen=%b, required 0", busy_seen);
        end
        check_quiet("glitch", 1'b0);

        // Framing error followed by a long break
        send_frame(8'hA5, 1'b0, 1'b0);
        check_frame("ferr_A5", EV_FE, 8'hA5);
        hold(1'b0, 2000);
        check_quiet("break_hold", 1'b1);
        hold(1'b1, CPB);
        check_quiet("break_release", 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_frame("after_break_3C", EV_DV, 8'h3C);
        hold(1'b1, CPB);

        // Reset in the middle of data bit 4 of 0xFF
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b1, CPB);
        hold(1'b1, HALF);
        rst_n = 1'b0;
        last_good = 8'h00;
        hold(1'b1, 10);
        check_reset_outputs("midframe_reset");
        rst_n = 1'b1;
        hold(1'b1, 6 * CPB);
        check_quiet("after_reset_quiet", 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        check_frame("after_reset_12", EV_DV, 8'h12);
        hold(1'b1, CPB);

        // Randomised frames against the reference model
        for (int i = 0; i < 4; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            pb   = (PAR_BITS != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            k    = predict(stop, pb);
            send_frame(d, stop, pb);
            check_frame($sformatf("rand%0d", i), k, d);
            if (k == EV_FE) hold(1'b1, CPB);
            else if ($urandom_range(0, 1) != 0) hold(1'b1, 50);
        end

        hold(1'b1, CPB);
        check_quiet("final_idle", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
